dmem_vector_loader: RTL
=======================

// Module: dmem_vector_loader
// PURPOSE
//  Fills data memory through the 256-bit vector port (port B) from an external byte stream.
//  It preloads images and operand vectors before the SIMD processor runs.
//  Sits beside the processor on the dmem port-B write path, on the same clock.
//  Packs 32 bytes per vector word and issues one port-B write per word.
// PARAMETERS
//  DATA_W  256  vector word width; must be a multiple of BYTE_W
//  BYTE_W  8    stream byte width
//  ADDR_W  32   dmem byte-address width
//  CNT_W   16   word-count width
// PORTS
//  clk        in   1       system clock; all state changes on the rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       begin a transfer; sampled only in IDLE
//  abort      in   1       cancel the transfer; partial word discarded
//  base_addr  in   ADDR_W  byte address of the first vector word; latched at start
//  num_words  in   CNT_W   vector words to load; latched at start
//  s_valid    in   1       stream byte valid
//  s_data     in   BYTE_W  stream byte
//  s_ready    out  1       loader accepts a byte this cycle
//  mem_we     out  1       port-B write enable, one-cycle pulse per word
//  mem_addr   out  ADDR_W  port-B byte address
//  mem_wdata  out  DATA_W  packed vector word
//  busy       out  1       high in FILL or WRITE
//  done       out  1       one-cycle pulse when the transfer completes
//  words_done out  CNT_W   count of words written in the current transfer
// BEHAVIOUR
//  Reset: state=IDLE; all outputs, lane counter, word counter and packing register are 0.
//  Reset during a transfer behaves the same way: no write is issued and no done pulse occurs.
//  Byte acceptance: a byte is accepted on an edge where s_valid && s_ready.
//  s_ready is registered-state decoded and is high only in FILL.
//  Packing: the k-th accepted byte of a word (k=0..31) goes to bits [8k+7:8k], so byte order is little-endian.
//  FSM: IDLE -> FILL -> WRITE -> (FILL | DONE) -> IDLE.
//   IDLE: on start && !abort, latch base_addr and num_words and clear words_done.
//    If num_words==0, go to DONE; otherwise go to FILL.
//   FILL: on acceptance of byte 31 (lane counter wraps 31->0), go to WRITE.
//    s_valid gaps stall the transfer with no timeout.
//   WRITE: one cycle; mem_we=1, mem_addr=base+32*words_done, mem_wdata=packed word; s_ready=0.
//    On the next edge words_done increments.
//    If words_done+1==num_words, go to DONE; otherwise go to FILL.
//   DONE: done=1 for exactly one cycle, then IDLE. words_done holds until the next start.
//  Latency: the last byte is accepted at edge N; mem_we is high in cycle N+1.
//   For the final word, done is high in cycle N+2.
//  mem_addr and mem_wdata are valid only while mem_we=1. Otherwise they hold their last values.
//  mem_addr arithmetic is modulo 2^ADDR_W (wraps silently). base_addr alignment is not checked.
//  abort: honoured in FILL and WRITE with priority over everything else.
//   Next state is IDLE; no done pulse; the lane counter clears.
//   If abort coincides with a WRITE cycle, that write still occurs (mem_we is already high).
//  Simultaneous start and abort in IDLE: abort wins and the state stays IDLE.
//  start in any state other than IDLE is ignored.
//  Inputs change after the clock edge, so a byte presented during WRITE is not accepted.
//   The source must hold s_valid and s_data until s_ready.
// STRUCTURE
//  Shared package simd_mem_pkg holds:
//   loader_state_t enum {IDLE, FILL, WRITE, DONE}
//   VEC_BYTES = DATA_W/BYTE_W
//   LANE_W = $clog2(VEC_BYTES)
//  Sub-module byte_packer handles byte packing:
//   lane counter, DATA_W packing register, a wrap flag, and a clear input.
//   The top FSM, address generation and word counter stay in dmem_vector_loader.
// TESTING
//  T1: base=0x100, num=1, bytes 0x00..0x1F back-to-back
//   -> single mem_we, addr 0x100, wdata[7:0]=0x00, wdata[255:248]=0x1F; done two cycles after the last byte.
//  T2: num=3, s_valid toggling every other cycle
//   -> writes at 0x100, 0x120, 0x140; words_done=3; one done pulse; s_ready=0 in each WRITE cycle.
//  T3: start with num=0 -> done high on the next cycle; no mem_we; s_ready never high.
//  T4: abort after 10 bytes of word 0 -> IDLE next cycle, no mem_we, no done.
//   A later start with num=1 packs from lane 0 again.
//  T5: reset asserted after 20 bytes
//   -> all outputs 0 next cycle; a restarted transfer gives correct data at base.
//  T6: start pulsed while busy, and start && abort in IDLE
//   -> both ignored; the first transfer completes with unchanged addresses.

Source files
------------

// File: rtl/simd_mem_pkg.sv
// Shared types and geometry for the dmem port-B vector loader.
package simd_mem_pkg;

  localparam int DMEM_DATA_W = 256;
  localparam int DMEM_BYTE_W = 8;
  localparam int VEC_BYTES   = DMEM_DATA_W / DMEM_BYTE_W;
  localparam int LANE_W      = $clog2(VEC_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles a vector word from a byte stream, little-endian by acceptance order.
// wrap flags the edge on which the last lane of a word is filled.
module byte_packer
  import simd_mem_pkg::*;
#(
  parameter int BYTE_W = DMEM_BYTE_W,
  parameter int NB     = VEC_BYTES,
  parameter int LW     = LANE_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 acc,
  input  logic [BYTE_W-1:0]    din,
  output logic [NB*BYTE_W-1:0] word,
  output logic                 wrap
);

  logic [LW-1:0]              lane;
  logic [NB-1:0][BYTE_W-1:0]  lanes_q;
  logic                       take;

  // clr beats acc so an aborted partial word never advances the pointer
  assign take = acc && !clr;
  assign wrap = take && (lane == LW'(NB - 1));
  assign word = lanes_q;

  // lane pointer: advances per accepted byte, wraps after the last lane
  always_ff @(posedge clk) begin
    if (reset || clr)
      lane <= '0;
    else if (take)
      lane <= (lane == LW'(NB - 1)) ? '0 : lane + LW'(1);
  end

  // per-lane byte registers; only the addressed lane loads
  for (genvar i = 0; i < NB; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (reset)
        lanes_q[i] <= '0;
      else if (take && (lane == LW'(i)))
        lanes_q[i] <= din;
    end
  end

endmodule

// File: rtl/dmem_vector_loader.sv
// Streams bytes into vector words and writes each word to dmem port B.
// FSM, address generation and word counting live here; packing is in byte_packer.
module dmem_vector_loader
  import simd_mem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int BYTE_W = DMEM_BYTE_W,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              s_valid,
  input  logic [BYTE_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_done
);

  localparam int NB      = DATA_W / BYTE_W;
  localparam int LW      = $clog2(NB);
  localparam int ADDR_SH = $clog2(DATA_W / 8);

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] base_q, addr_hold, wr_addr;
  logic [CNT_W-1:0]  num_q;
  logic [DATA_W-1:0] data_hold, pk_word;
  logic              pk_wrap, pk_clr, abort_act, start_ok, last_word;

  assign s_ready   = (state == FILL);
  assign mem_we    = (state == WRITE);
  assign busy      = (state == FILL) || (state == WRITE);
  assign done      = (state == DONE);
  assign abort_act = abort && busy;
  assign start_ok  = (state == IDLE) && start && !abort;
  assign pk_clr    = abort_act || start_ok;
  assign last_word = (words_done + CNT_W'(1)) == num_q;
  // address wraps modulo 2^ADDR_W by construction
  assign wr_addr   = base_q + (ADDR_W'(words_done) << ADDR_SH);

  // write-port outputs follow the live word during WRITE, otherwise hold
  assign mem_addr  = mem_we ? wr_addr : addr_hold;
  assign mem_wdata = mem_we ? pk_word : data_hold;

  byte_packer #(
    .BYTE_W (BYTE_W),
    .NB     (NB),
    .LW     (LW)
  ) u_packer (
    .clk   (clk),
    .reset (reset),
    .clr   (pk_clr),
    .acc   (s_valid && s_ready),
    .din   (s_data),
    .word  (pk_word),
    .wrap  (pk_wrap)
  );

  // next-state: abort outranks all progress in FILL/WRITE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = (num_words == '0) ? DONE : FILL;
      FILL:    if (abort) state_nxt = IDLE;
               else if (pk_wrap) state_nxt = WRITE;
      WRITE:   if (abort) state_nxt = IDLE;
               else state_nxt = last_word ? DONE : FILL;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, transfer latches, word counter and output hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      words_done <= '0;
      addr_hold  <= '0;
      data_hold  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        base_q     <= base_addr;
        num_q      <= num_words;
        words_done <= '0;
      end
      // the write in WRITE always lands, even when aborted, so it is counted
      if (state == WRITE) begin
        words_done <= words_done + CNT_W'(1);
        addr_hold  <= wr_addr;
        data_hold  <= pk_word;
      end
    end
  end

endmodule
